trig_exe_scheduler: RTL
=======================

Name: trig_exe_scheduler

Overview:
- Sequences the multi-cycle trigonometric unit for SIN/COS instructions in the EXE stage.
- Issues a start pulse to the trig unit and stalls fetch/decode/exe until the unit completes, a branch flush arrives, or a timeout fires.
- Presents a one-cycle result-valid window to the EXE/MEM register.
- Sits between the decode→exe control register (trigControl field) and the trig unit; also keeps saturating performance counters.

Parameters:
- TIMEOUT, 32, max BUSY cycles waited for trig_done_i before aborting; must be ≥2.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous reset, active-low
- ex_valid_i  input  1  EXE stage holds a valid instruction
- ex_trig_i  input  1  trigControl of the instruction in EXE
- ex_trig_op_i  input  1  0=SIN, 1=COS
- ex_flush_i  input  1  branch taken / pipeline flush (pcSrc)
- trig_done_i  input  1  trig unit result ready (one-cycle pulse)
- trig_start_o  output  1  one-cycle start pulse to trig unit
- trig_sel_o  output  1  latched op select, stable while BUSY
- trig_abort_o  output  1  one-cycle abort to trig unit
- stall_o  output  1  freeze PC, F/D and D/E registers
- result_valid_o  output  1  trig result may be written back this cycle
- timeout_err_o  output  1  sticky timeout flag
- op_cnt_o  output  CNT_W  completed (non-aborted, non-timed-out) trig ops, saturating
- stall_cnt_o  output  CNT_W  cycles with stall_o=1, saturating

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; all outputs 0; counters 0; timeout_err_o cleared.
  - Reset mid-BUSY does not pulse trig_abort_o; the trig unit shares the reset.
- req = ex_valid_i & ex_trig_i & ~ex_flush_i.
- States: IDLE, BUSY, DONE.
- IDLE:
  - stall_o = req (combinational).
  - On req: latch trig_sel_o = ex_trig_op_i, clear the wait counter, go to BUSY.
  - trig_done_i is ignored in IDLE.
- BUSY:
  - trig_start_o=1 on the first BUSY cycle only (registered).
  - stall_o=1; the wait counter increments each BUSY cycle.
  - Priority, highest first: ex_flush_i > trig_done_i > timeout.
  - ex_flush_i: trig_abort_o=1 that cycle; go to IDLE. op_cnt is not incremented.
  - trig_done_i: go to DONE.
  - Counter == TIMEOUT-1 without done: trig_abort_o=1, set timeout_err_o, go to DONE with the timed-out flag set.
  - trig_done_i on the same cycle as trig_start_o is legal and goes to DONE.
- DONE (exactly one cycle):
  - stall_o=0 so the instruction advances.
  - result_valid_o = ~timed_out.
  - op_cnt_o increments if not timed out.
  - Go to IDLE. A back-to-back trig instruction is then seen in IDLE on the next cycle.
  - ex_flush_i in DONE forces result_valid_o=0; the op is not counted.
- Latency:
  - req at cycle T; trig_start_o at T+1; trig_done_i at T+1+k gives DONE at T+2+k.
  - stall_o is high for k+2 cycles.
- Counters:
  - stall_cnt_o adds 1 on every cycle with stall_o=1.
  - Both counters saturate at all-ones and never wrap.
- trig_sel_o holds its value until the next issue.
- ex_trig_op_i changes during BUSY are ignored.
- Non-trig instructions (ex_trig_i=0) never stall and never start the unit.

Test Plan:
- Reset then COS issue: ex_valid_i=1, ex_trig_i=1, ex_trig_op_i=1 at T; trig_done_i at T+5 → trig_start_o at T+1 only, trig_sel_o=1, stall_o high T..T+5 (6 cycles), result_valid_o=1 at T+6, op_cnt_o=1, stall_cnt_o=6.
- Flush during BUSY: ex_flush_i=1 at T+3 with trig_done_i=1 at T+3 → trig_abort_o=1 at T+3, state IDLE at T+4, result_valid_o never asserted, op_cnt_o unchanged.
- Timeout: TIMEOUT=32, trig_done_i never asserted → trig_abort_o at the 32nd BUSY cycle, timeout_err_o=1 and remains 1, result_valid_o=0 in DONE; a subsequent SIN op completes normally with timeout_err_o still 1.
- Back-to-back SIN then COS, each done after 3 cycles → two trig_start_o pulses separated by 6 cycles, trig_sel_o 0 then 1, op_cnt_o=2, no duplicate start.
- Non-trig traffic (ex_valid_i=1, ex_trig_i=0) for 10 cycles → stall_o=0, trig_start_o=0, counters stay 0.
- Reset mid-BUSY (rst_n=0 at T+2) → next cycle all outputs 0, trig_abort_o not pulsed; CNT_W=4 run of 20 stall cycles → stall_cnt_o saturates at 15.

Source files
------------

// File: rtl/trig_exe_scheduler.sv
// Sequencer for the multi-cycle trig unit used by SIN/COS in the EXE stage.
// It issues a start pulse, stalls the front of the pipeline while the unit
// works, and aborts the unit on a flush or when it takes too long. It also
// opens a one-cycle result window to EXE/MEM and keeps saturating
// performance counters.
module trig_exe_scheduler #(
    parameter int TIMEOUT = 32,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid_i,
    input  logic             ex_trig_i,
    input  logic             ex_trig_op_i,
    input  logic             ex_flush_i,
    input  logic             trig_done_i,
    output logic             trig_start_o,
    output logic             trig_sel_o,
    output logic             trig_abort_o,
    output logic             stall_o,
    output logic             result_valid_o,
    output logic             timeout_err_o,
    output logic [CNT_W-1:0] op_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    // The wait counter only has to reach TIMEOUT-1, so it never wraps.
    localparam int                WAIT_W    = $clog2(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              sel_q, sel_d;
    logic              start_q, start_d;
    logic              timed_out_q, timed_out_d;
    logic              terr_q, terr_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  op_cnt_q, op_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic req;
    logic stall;
    logic abort;
    logic rvalid;

    // A trig instruction that is being flushed is not a request.
    assign req = ex_valid_i & ex_trig_i & ~ex_flush_i;

    // Next-state logic and the combinational handshake outputs.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        wait_d      = wait_q;
        timed_out_d = timed_out_q;
        terr_d      = terr_q;
        stall       = 1'b0;
        abort       = 1'b0;
        rvalid      = 1'b0;
        case (state_q)
            S_IDLE: begin
                stall = req;
                if (req) begin
                    sel_d       = ex_trig_op_i;
                    wait_d      = '0;
                    timed_out_d = 1'b0;
                    state_d     = S_BUSY;
                end
            end
            S_BUSY: begin
                stall  = 1'b1;
                wait_d = wait_q + 1'b1;
                // Flush beats done, and done beats the timeout.
                if (ex_flush_i) begin
                    abort   = 1'b1;
                    state_d = S_IDLE;
                end else if (trig_done_i) begin
                    state_d = S_DONE;
                end else if (wait_q == WAIT_LAST) begin
                    abort       = 1'b1;
                    terr_d      = 1'b1;
                    timed_out_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                rvalid  = ~timed_out_q & ~ex_flush_i;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The start pulse is registered so it lands on the first BUSY cycle.
        start_d = (state_q == S_IDLE) & req;

        op_cnt_d = op_cnt_q;
        if (rvalid && (op_cnt_q != CNT_MAX)) begin
            op_cnt_d = op_cnt_q + 1'b1;
        end

        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // State, latched op select, flags and counters; the trig unit shares
    // this reset, so reset never emits an abort.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            sel_q       <= 1'b0;
            start_q     <= 1'b0;
            timed_out_q <= 1'b0;
            terr_q      <= 1'b0;
            wait_q      <= '0;
            op_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            start_q     <= start_d;
            timed_out_q <= timed_out_d;
            terr_q      <= terr_d;
            wait_q      <= wait_d;
            op_cnt_q    <= op_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign trig_start_o   = start_q;
    assign trig_sel_o     = sel_q;
    assign trig_abort_o   = abort;
    assign stall_o        = stall;
    assign result_valid_o = rvalid;
    assign timeout_err_o  = terr_q;
    assign op_cnt_o       = op_cnt_q;
    assign stall_cnt_o    = stall_cnt_q;

endmodule
